pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Reset sequencer placed directly downstream of the 48→100 MHz PLL wrapper; runs on the PLL output clock. Synchronises the PLL `locked` flag, requires it to stay high for a programmable settle window, then holds the fabric reset for a further interval before releasing it. Any loss of lock re-asserts reset at once and restarts the sequence. Core logic in the 100 MHz domain takes `reset_out` as its synchronous reset.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth for `locked`, ≥2.
- `STABLE_CYCLES`, 1024: consecutive synchronised-high cycles of `locked` required, ≥1.
- `HOLD_CYCLES`, 16: cycles `reset_out` stays high after the stable window, ≥1.
- `CNT_W`, 8: width of the lock-loss counter.

- `clock_in` in 1: 100 MHz PLL output clock (the PLL's `clock_out`).
- `reset` in 1: synchronous, active-high.
- `locked` in 1: PLL lock flag; asynchronous to `clock_in`.
- `reset_out` out 1: synchronous active-high reset for downstream logic; registered.
- `ready` out 1: high exactly when `reset_out` is low; registered.
- `loss_count` out CNT_W: saturating count of lock losses seen while in RUN.

## Operation
- Reset values: state WAIT_LOCK, all synchroniser flops 0, counter 0, `reset_out`=1, `ready`=0, `loss_count`=0.
- `locked_s` is the last synchroniser stage. It is the only signal the FSM reads.
- WAIT_LOCK: if `locked_s`=1, go to STABLE with counter=0.
- STABLE: if `locked_s`=0, go to WAIT_LOCK.
  - Else if counter==STABLE_CYCLES-1, go to HOLD with counter=0.
  - Else increment the counter.
- HOLD: if `locked_s`=0, go to WAIT_LOCK.
  - Else if counter==HOLD_CYCLES-1, go to RUN.
  - Else increment the counter.
- RUN: if `locked_s`=0, go to WAIT_LOCK and increment `loss_count`.
- `reset_out`/`ready` are registered with the state: `reset_out`=0 and `ready`=1 only in RUN.
- The counter is wide enough for max(STABLE_CYCLES, HOLD_CYCLES)-1. It never wraps, because it is cleared on every transition.
- `loss_count` saturates at 2^CNT_W-1. Only `reset` clears it.
- A loss of lock in STABLE or HOLD restarts the sequence but does not increment `loss_count`.
- `reset` high on any edge: every register returns to its reset value on that edge, whatever the current state.

## Timing
- Edge 0 is the first edge sampling `locked`=1. Then:
  - `locked_s`=1 after edge SYNC_STAGES-1.
  - STABLE after edge SYNC_STAGES.
  - HOLD after edge SYNC_STAGES+STABLE_CYCLES.
  - `reset_out` falls and `ready` rises after edge SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES.
- Edge m is the first edge sampling `locked`=0. `reset_out` rises and `ready` falls after edge m+SYNC_STAGES. `loss_count` updates on the same edge.
- A `locked` pulse shorter than one clock may be missed. This is acceptable.
- `reset_out` never glitches: it comes from a single flop.

## Configuration
- Macro `PLL_RESET_SEQ_LOSS_CNT_EN`.
- Defined: the `loss_count` register and its saturating increment are built as described above.
- Not defined: no counter logic; `loss_count` is tied to 0. Port list unchanged.

## Structure
- Package `pll_reset_pkg`:
  - state typedef (WAIT_LOCK, STABLE, HOLD, RUN; 2-bit encoding);
  - helper constant/function for the counter width.
- Sub-module `sync_ff`: parameterised depth, reset-to-0 synchroniser chain. Instantiated once for `locked`.

## Test plan
Parameters for all tests: SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=2, CNT_W=2.
- Power-up: hold `reset` 3 cycles with `locked`=1, then release at edge 0 → `reset_out`=1 through edge 7; `reset_out`=0 and `ready`=1 after edge 8.
- Glitch in STABLE: drop `locked` for 1 cycle at edge 4 → state returns to WAIT_LOCK and the sequence restarts; `reset_out` stays 1; `loss_count`=0.
- Loss in RUN: drop `locked` at edge m → `reset_out`=1 after edge m+2 and `loss_count`=1; restoring `locked` releases reset 8 edges after it is first sampled high.
- Saturation: 5 losses in RUN → `loss_count` reads 1, 2, 3, 3, 3. With the macro undefined, `loss_count` is always 0.
- Reset mid-HOLD: assert `reset` in HOLD → `reset_out`=1, `ready`=0, `loss_count`=0 after that edge; the full 8-edge sequence repeats after release.

Source files
------------

// File: rtl/pll_reset_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and counter sizing.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Bits needed to hold max(stable_cycles, hold_cycles)-1, never less than one.
    function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
        int top;
        top = ((stable_cycles > hold_cycles) ? stable_cycles : hold_cycles) - 1;
        return (top < 2) ? 1 : $clog2(top + 1);
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync_ff.sv
// Reset-to-0 flop chain bringing an asynchronous level into the local clock domain.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic stage_reg [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (srst) stage_reg[gi] <= 1'b0;
                    else      stage_reg[gi] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (srst) stage_reg[gi] <= 1'b0;
                    else      stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock -> fabric reset sequencer. Optional lock-loss counter is built when
// PLL_RESET_SEQ_LOSS_CNT_EN is defined; otherwise loss_count is tied to 0.
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             locked,
    output logic             reset_out,
    output logic             ready,
    output logic [CNT_W-1:0] loss_count
);

    localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    logic          locked_s;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          reset_out_reg;
    logic          ready_reg;

    sync_ff #(.DEPTH(SYNC_STAGES)) u_lock_sync (
        .clk  (clock_in),
        .srst (reset),
        .d    (locked),
        .q    (locked_s)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from state_next so they change on the same edge as the state.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_reg     <= WAIT_LOCK;
            cnt_reg       <= '0;
            reset_out_reg <= 1'b1;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            reset_out_reg <= (state_next != RUN);
            ready_reg     <= (state_next == RUN);
        end
    end

    assign reset_out = reset_out_reg;
    assign ready     = ready_reg;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_reg;
    logic             loss_event;

    // Only a loss while running counts; drops during STABLE/HOLD just restart.
    assign loss_event = (state_reg == RUN) && !locked_s;

    always_ff @(posedge clock_in) begin
        if (reset)                            loss_reg <= '0;
        else if (loss_event && loss_reg != '1) loss_reg <= loss_reg + 1'b1;
    end

    assign loss_count = loss_reg;
`else
    assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq with SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=2, CNT_W=2.
module tb_pll_reset_seq;

    logic       clock_in;
    logic       reset;
    logic       locked;
    logic       reset_out;
    logic       ready;
    logic [1:0] loss_count;

    typedef struct {
        logic       ro;
        logic [1:0] loss;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   loss_exp = 0;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    int sat_tbl [5] = '{1, 2, 3, 3, 3};
`else
    int sat_tbl [5] = '{0, 0, 0, 0, 0};
`endif

    pll_reset_seq #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .HOLD_CYCLES   (2),
        .CNT_W         (2)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .locked     (locked),
        .reset_out  (reset_out),
        .ready      (ready),
        .loss_count (loss_count)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Each entry describes the outputs expected just after the next rising edge.
    task automatic run(input int n, input logic r, input logic l, input logic ro,
                       input int loss, input string name);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clock_in);
            reset  = r;
            locked = l;
            e.ro   = ro;
            e.loss = 2'(loss);
            e.name = name;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: one output sample per edge, compared against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (reset_out !== e.ro || ready !== !e.ro || loss_count !== e.loss) begin
                    n_miss++;
                    $display("FAIL %s: got reset_out=%b ready=%b loss_count=%0d, want reset_out=%b ready=%b loss_count=%0d",
                             e.name, reset_out, ready, loss_count, e.ro, !e.ro, e.loss);
                end else begin
                    $display("ok   %s: reset_out=%b ready=%b loss_count=%0d",
                             e.name, reset_out, ready, loss_count);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        locked = 1'b0;

        // Power-up: reset held with locked high, release sequence takes 8 edges.
        run(3, 1'b1, 1'b1, 1'b1, 0, "reset_state");
        run(8, 1'b0, 1'b1, 1'b1, 0, "powerup_hold");
        run(1, 1'b0, 1'b1, 1'b0, 0, "powerup_release");
        run(2, 1'b0, 1'b1, 1'b0, 0, "run_steady");

        // One-cycle glitch at edge 4 while STABLE: restart from edge 5.
        run(2, 1'b1, 1'b1, 1'b1, 0, "glitch_reset");
        run(4, 1'b0, 1'b1, 1'b1, 0, "glitch_pre");
        run(1, 1'b0, 1'b0, 1'b1, 0, "glitch_drop");
        run(8, 1'b0, 1'b1, 1'b1, 0, "glitch_restart");
        run(1, 1'b0, 1'b1, 1'b0, 0, "glitch_release");
        run(2, 1'b0, 1'b1, 1'b0, 0, "glitch_run");

        // Five losses in RUN, locked low for three edges each, then relock.
        for (int k = 0; k < 5; k++) begin
            run(2, 1'b0, 1'b0, 1'b0, loss_exp,   "loss_sync_delay");
            run(1, 1'b0, 1'b0, 1'b1, sat_tbl[k], "loss_reassert");
            loss_exp = sat_tbl[k];
            run(8, 1'b0, 1'b1, 1'b1, loss_exp,   "loss_relock_hold");
            run(1, 1'b0, 1'b1, 1'b0, loss_exp,   "loss_relock_release");
            run(1, 1'b0, 1'b1, 1'b0, loss_exp,   "loss_run");
        end

        // Drive into HOLD, then reset there; full sequence must repeat.
        run(2, 1'b0, 1'b0, 1'b0, loss_exp,   "hold_drop");
        run(1, 1'b0, 1'b0, 1'b1, loss_exp,   "hold_reassert");
        run(7, 1'b0, 1'b1, 1'b1, loss_exp,   "hold_approach");
        run(1, 1'b1, 1'b1, 1'b1, 0,          "hold_reset");
        run(8, 1'b0, 1'b1, 1'b1, 0,          "hold_reseq");
        run(1, 1'b0, 1'b1, 1'b0, 0,          "hold_reseq_release");
        run(2, 1'b0, 1'b1, 1'b0, 0,          "hold_reseq_run");

        @(posedge clock_in);
        #2;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
